// File: rtl/result_checker_pkg.sv
// Shared types and constants for the result checker: FSM state encoding and
// the byte mask that selects the done-flag byte out of byte lane 0.
package result_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_FETCH  = 3'd2,
    ST_REQ    = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  // The done flag lives in byte lane 0 of the snooped write; only these bits
  // of dm_wdata[7:0] take part in the done-value match.
  localparam logic [7:0] DONE_BYTE_MASK = 8'hff;

endpackage

// File: rtl/result_checker_if.sv
// Bundle of the checker's snoop, read, golden-ROM and status signals.
//
// Read handshake: the checker raises rd_req with rd_addr and holds both
// unchanged until a cycle in which rd_valid=1; that cycle is the transfer and
// rd_data is consumed then. rd_valid has no meaning while rd_req=0. There is
// no back-pressure on the checker side and at most one read is outstanding.
interface result_checker_if
  import result_checker_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int NUM_WORDS = 74,
  parameter int ERR_W     = 16
) ();
  localparam int GA_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  logic                  start;
  logic [DATA_W/8-1:0]   dm_we;
  logic [ADDR_W-1:0]     dm_addr;
  logic [DATA_W-1:0]     dm_wdata;
  logic                  rd_req;
  logic [ADDR_W-1:0]     rd_addr;
  logic                  rd_valid;
  logic [DATA_W-1:0]     rd_data;
  logic [GA_W-1:0]       gold_addr;
  logic [DATA_W-1:0]     gold_data;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic                  timeout;
  logic [ERR_W-1:0]      err_count;
  logic                  mism_valid;
  logic [15:0]           mism_index;
  logic [DATA_W-1:0]     mism_got;
  logic [DATA_W-1:0]     mism_exp;
  state_e                dbg_state;

  modport master (
    input  start, dm_we, dm_addr, dm_wdata, rd_valid, rd_data, gold_data,
    output rd_req, rd_addr, gold_addr, busy, done, pass, timeout, err_count,
           mism_valid, mism_index, mism_got, mism_exp, dbg_state
  );

  modport slave (
    output start, dm_we, dm_addr, dm_wdata, rd_valid, rd_data, gold_data,
    input  rd_req, rd_addr, gold_addr, busy, done, pass, timeout, err_count,
           mism_valid, mism_index, mism_got, mism_exp, dbg_state
  );

endinterface

// File: rtl/result_checker_cycle_watchdog.sv
// Cycle counter that flags expiry once MAX_CYCLES-1 counted cycles have
// elapsed since the last clear. It stops at the limit so expired stays high.
module cycle_watchdog #(
  parameter int MAX_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: clear wins, otherwise count while enabled up to the limit.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LIMIT)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LIMIT);

endmodule

// File: rtl/result_checker.sv
// Result checker: waits for a program to write its done flag, then reads the
// answer words back from data memory one at a time and compares each against
// a registered golden ROM, reporting mismatches and a final pass/fail.
module result_checker
  import result_checker_pkg::*;
#(
  parameter int                ADDR_W       = 16,
  parameter int                DATA_W       = 32,
  parameter logic [ADDR_W-1:0] ANSWER_START = 'h9000,
  parameter int                NUM_WORDS    = 74,
  parameter logic [ADDR_W-1:0] DONE_ADDR    = 'hfffc,
  parameter logic [7:0]        DONE_VAL     = 8'hff,
  parameter int                MAX_CYCLES   = 100000,
  parameter int                ERR_W        = 16
) (
  input logic              clk,
  input logic              rst,
  result_checker_if.master bus
);
  localparam int IDX_W = (NUM_WORDS > 0) ? $clog2(NUM_WORDS + 1) : 1;
  localparam int GA_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'((NUM_WORDS > 0) ? (NUM_WORDS - 1) : 0);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               timeout_q, timeout_d;

  logic done_wr;
  logic xfer;
  logic mism;
  logic wd_clear;
  logic wd_en;
  logic wd_expired;

  cycle_watchdog #(
    .MAX_CYCLES (MAX_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (wd_en),
    .expired (wd_expired)
  );

  // Decode the snooped bus and the read handshake for the current cycle.
  always_comb begin
    done_wr = bus.dm_we[0] && (bus.dm_addr == DONE_ADDR) &&
              ((bus.dm_wdata[7:0] & DONE_BYTE_MASK) == DONE_VAL);
    xfer    = (state_q == ST_REQ) && bus.rd_valid;
    mism    = xfer && (bus.rd_data !== bus.gold_data);
    wd_en   = (state_q == ST_ARMED);
  end

  // Next-state logic; arming clears all per-run results and the watchdog.
  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    err_d     = err_q;
    timeout_d = timeout_q;
    wd_clear  = 1'b0;
    case (state_q)
      ST_IDLE, ST_FINISH: begin
        if (bus.start) begin
          state_d   = ST_ARMED;
          index_d   = '0;
          err_d     = '0;
          timeout_d = 1'b0;
          wd_clear  = 1'b1;
        end
      end
      ST_ARMED: begin
        // A done write beats a watchdog expiry in the same cycle.
        if (done_wr) begin
          state_d = (NUM_WORDS == 0) ? ST_FINISH : ST_FETCH;
        end else if (wd_expired) begin
          state_d   = ST_FINISH;
          timeout_d = 1'b1;
        end
      end
      ST_FETCH: begin
        // gold_addr already shows index; the ROM answers next cycle.
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (xfer) begin
          if (mism && (err_q != {ERR_W{1'b1}})) begin
            err_d = err_q + ERR_W'(1);
          end
          if (index_q == LAST_IDX) begin
            state_d = ST_FINISH;
          end else begin
            index_d = index_q + IDX_W'(1);
            state_d = ST_FETCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      index_q   <= '0;
      err_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
    end
  end

  // Outputs are decoded from state so reset leaves every one of them at zero.
  assign bus.rd_req     = (state_q == ST_REQ);
  assign bus.rd_addr    = (state_q == ST_REQ) ?
                          (ANSWER_START + (ADDR_W'(index_q) << 2)) : '0;
  assign bus.gold_addr  = GA_W'(index_q);
  assign bus.busy       = (state_q == ST_ARMED) || (state_q == ST_FETCH) ||
                          (state_q == ST_REQ);
  assign bus.done       = (state_q == ST_FINISH);
  assign bus.pass       = (state_q == ST_FINISH) && (err_q == '0) && !timeout_q;
  assign bus.timeout    = timeout_q;
  assign bus.err_count  = err_q;
  assign bus.mism_valid = mism;
  assign bus.mism_index = mism ? 16'(index_q) : 16'h0;
  assign bus.mism_got   = mism ? bus.rd_data : '0;
  assign bus.mism_exp   = mism ? bus.gold_data : '0;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_result_checker.sv
// Bench for result_checker: drives the snoop bus, models data memory with a
// variable-latency read responder and a registered golden ROM, and checks
// every transfer against a word-level reference of what must be read.
module tb_result_checker;
  import result_checker_pkg::*;

  localparam int AW = 16, DW = 32, NW = 6, EW = 2, MAXC = 20;
  localparam logic [15:0] ANS   = 16'h9000;
  localparam logic [15:0] DADDR = 16'hfffc;
  localparam logic [7:0]  DVAL  = 8'hff;
  localparam int ERR_MAX = (1 << EW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  result_checker_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(NW), .ERR_W(EW)) bus ();

  result_checker #(
    .ADDR_W(AW), .DATA_W(DW), .ANSWER_START(ANS), .NUM_WORDS(NW),
    .DONE_ADDR(DADDR), .DONE_VAL(DVAL), .MAX_CYCLES(MAXC), .ERR_W(EW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- model state ----------------
  int n_vec = 0;
  int n_fail = 0;
  logic [DW-1:0] dm_mem [NW];
  logic [DW-1:0] gold_mem [NW];
  logic [AW-1:0] exp_q [$];
  logic [AW-1:0] xfer_log [$];
  int xfer_idx;
  int mism_seen;
  int last_mi;
  logic [DW-1:0] last_got, last_exp;
  bit prev_pending;
  logic [AW-1:0] prev_addr;
  int resp_cnt = 0;
  int resp_dly = 0;
  int dly_ptr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int count_mism();
    int m = 0;
    for (int i = 0; i < NW; i++) if (dm_mem[i] !== gold_mem[i]) m++;
    return m;
  endfunction

  function automatic logic [DW-1:0] dm_read(input logic [AW-1:0] a);
    logic [AW-1:0] off;
    off = a - ANS;
    if (off[1:0] == 2'b00 && int'(off >> 2) < NW) return dm_mem[off >> 2];
    return $urandom;
  endfunction

  // Expected read sequence: every answer word in order, modulo 2^AW.
  task automatic build_model();
    exp_q.delete();
    xfer_log.delete();
    xfer_idx = 0;
    mism_seen = 0;
    last_mi = -1;
    for (int i = 0; i < NW; i++) exp_q.push_back(ANS + AW'(4 * i));
  endtask

  // ---------------- environment models ----------------
  // Registered golden ROM.
  always @(posedge clk) begin
    if (int'(bus.gold_addr) < NW) bus.gold_data <= gold_mem[bus.gold_addr];
    else bus.gold_data <= '0;
  end

  // DM read responder: latency cycles through 0, 1, 5 and a random value;
  // rd_valid is noise whenever no read is requested.
  always @(posedge clk) begin
    #2;
    if (bus.rd_req) begin
      if (resp_cnt >= resp_dly) begin
        bus.rd_valid = 1'b1;
        bus.rd_data  = dm_read(bus.rd_addr);
      end else begin
        bus.rd_valid = 1'b0;
        bus.rd_data  = $urandom;
        resp_cnt++;
      end
    end else begin
      bus.rd_valid = 1'($urandom_range(0, 1));
      bus.rd_data  = $urandom;
      resp_cnt = 0;
      case (dly_ptr % 4)
        0: resp_dly = 0;
        1: resp_dly = 1;
        2: resp_dly = 5;
        default: resp_dly = $urandom_range(0, 3);
      endcase
    end
    if (!bus.rd_req) dly_ptr++;
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [AW-1:0] a;
    bit em;
    if (rst) begin
      prev_pending = 0;
    end else if (bus.rd_req) begin
      if (exp_q.size() == 0) begin
        check("rd_req_unexpected", bus.rd_req, 1'b0);
      end else begin
        if (prev_pending) check("rd_addr_stable", bus.rd_addr, prev_addr);
        if (bus.rd_valid) begin
          a = exp_q.pop_front();
          check("rd_addr", bus.rd_addr, a);
          if (xfer_idx < NW) begin
            em = (dm_mem[xfer_idx] !== gold_mem[xfer_idx]);
            check("mism_valid_xfer", bus.mism_valid, em);
            if (em && bus.mism_valid) begin
              check("mism_index", bus.mism_index, xfer_idx);
              check("mism_got", bus.mism_got, dm_mem[xfer_idx]);
              check("mism_exp", bus.mism_exp, gold_mem[xfer_idx]);
              mism_seen++;
              last_mi  = int'(bus.mism_index);
              last_got = bus.mism_got;
              last_exp = bus.mism_exp;
            end
          end
          xfer_log.push_back(bus.rd_addr);
          xfer_idx++;
          prev_pending = 0;
        end else begin
          check("mism_valid_wait", bus.mism_valid, 1'b0);
          prev_pending = 1;
          prev_addr = bus.rd_addr;
        end
      end
    end else begin
      check("mism_valid_idle", bus.mism_valid, 1'b0);
      prev_pending = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_done();
    bus.dm_we    = 4'($urandom) | 4'b0001;
    bus.dm_addr  = DADDR;
    bus.dm_wdata = {24'($urandom), DVAL};
  endtask

  // Snoop traffic that is never a valid done write.
  task automatic armed_noise();
    if ($urandom_range(0, 3) == 0) begin
      bus.dm_we    = 4'($urandom) & 4'b1110;
      bus.dm_addr  = DADDR;
      bus.dm_wdata = {24'($urandom), DVAL};
    end else begin
      bus.dm_we    = 4'($urandom);
      bus.dm_addr  = 16'($urandom);
      if (bus.dm_addr == DADDR) bus.dm_addr = 16'h0;
      bus.dm_wdata = $urandom;
    end
  endtask

  // Snoop traffic including valid done writes, which must be ignored.
  task automatic busy_noise();
    if ($urandom_range(0, 2) == 0) drive_done();
    else armed_noise();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_req"}, bus.rd_req, 1'b0);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_done"}, bus.done, 1'b0);
    check({tag, "_pass"}, bus.pass, 1'b0);
    check({tag, "_timeout"}, bus.timeout, 1'b0);
    check({tag, "_mism_valid"}, bus.mism_valid, 1'b0);
    check({tag, "_err_count"}, bus.err_count, 0);
    check({tag, "_rd_addr"}, bus.rd_addr, 0);
    check({tag, "_gold_addr"}, bus.gold_addr, 0);
    check({tag, "_mism_index"}, bus.mism_index, 0);
    check({tag, "_mism_got"}, bus.mism_got, 0);
    check({tag, "_mism_exp"}, bus.mism_exp, 0);
    check({tag, "_state"}, bus.dbg_state, ST_IDLE);
  endtask

  task automatic fill_gold_equal();
    for (int i = 0; i < NW; i++) begin
      gold_mem[i] = $urandom;
      dm_mem[i]   = gold_mem[i];
    end
  endtask

  // One full run: arm, optional rejected done writes, valid done write in
  // ARMED cycle k_done, then the checking phase to completion.
  task automatic run_check(input int k_done, input bit bogus);
    int m;
    int exp_err;
    m = count_mism();
    exp_err = (m > ERR_MAX) ? ERR_MAX : m;
    build_model();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 0; c <= k_done; c++) begin
      check("armed_busy", bus.busy, 1'b1);
      check("armed_done", bus.done, 1'b0);
      if (c == k_done) begin
        drive_done();
      end else if (bogus && c == 2) begin
        bus.dm_we = 4'b0001; bus.dm_addr = DADDR; bus.dm_wdata = {24'($urandom), 8'hfe};
      end else if (bogus && c == 4) begin
        bus.dm_we = 4'b0010; bus.dm_addr = DADDR; bus.dm_wdata = {24'($urandom), DVAL};
      end else begin
        armed_noise();
        if (c == 1) bus.start = 1'b1;
      end
      step();
      bus.start = 1'b0;
    end
    for (int w = 0; w < 300 && !bus.done; w++) begin
      busy_noise();
      step();
    end
    bus.dm_we = '0;
    check("run_done", bus.done, 1'b1);
    check("run_busy", bus.busy, 1'b0);
    check("run_err_count", bus.err_count, exp_err);
    check("run_pass", bus.pass, (m == 0));
    check("run_timeout", bus.timeout, 1'b0);
    check("run_xfers", xfer_idx, NW);
    check("run_mism_pulses", mism_seen, m);
    drive_done();
    step();
    bus.dm_we = '0;
    check("finish_hold_done", bus.done, 1'b1);
    check("finish_hold_busy", bus.busy, 1'b0);
    check("finish_hold_err", bus.err_count, exp_err);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.start = 1'b0;
    bus.dm_we = '0;
    bus.dm_addr = '0;
    bus.dm_wdata = '0;
    fill_gold_equal();
    rst = 1'b1;
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    // All words match; done write at armed cycle 8.
    fill_gold_equal();
    run_check(8, 1'b0);
    check("all_ok_pass_lit", bus.pass, 1'b1);
    if (xfer_log.size() >= 4) begin
      check("addr_first_lit", xfer_log[0], 16'h9000);
      check("addr_fourth_lit", xfer_log[3], 16'h900c);
    end else begin
      check("xfer_log_len", xfer_log.size(), 4);
    end

    // Single mismatch at word 2: DM 1 vs golden 2.
    fill_gold_equal();
    gold_mem[2] = 32'h2;
    dm_mem[2]   = 32'h1;
    run_check(5, 1'b0);
    check("one_mism_err_lit", bus.err_count, 1);
    check("one_mism_pass_lit", bus.pass, 1'b0);
    check("one_mism_index_lit", last_mi, 2);
    check("one_mism_got_lit", last_got, 32'h1);
    check("one_mism_exp_lit", last_exp, 32'h2);

    // No done write: watchdog finishes 20 cycles after arming, no reads.
    fill_gold_equal();
    exp_q.delete();
    xfer_idx = 0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 0; c < MAXC; c++) begin
      check("wd_busy", bus.busy, 1'b1);
      check("wd_done", bus.done, 1'b0);
      armed_noise();
      if (c == 10) bus.start = 1'b1;
      step();
      bus.start = 1'b0;
    end
    bus.dm_we = '0;
    check("wd_finish_done", bus.done, 1'b1);
    check("wd_timeout", bus.timeout, 1'b1);
    check("wd_pass", bus.pass, 1'b0);
    check("wd_busy_end", bus.busy, 1'b0);
    check("wd_no_reads", xfer_idx, 0);

    // Rejected done writes (wrong byte value, wrong lane), then a valid one.
    fill_gold_equal();
    run_check(9, 1'b1);

    // Five mismatches saturate a 2-bit counter; done write on expiry cycle.
    fill_gold_equal();
    for (int i = 0; i < 5; i++) dm_mem[i] = ~gold_mem[i];
    run_check(MAXC - 1, 1'b0);
    check("sat_err_lit", bus.err_count, 3);

    // Reset while a read is outstanding.
    fill_gold_equal();
    dm_mem[0] = gold_mem[0] ^ 32'h10;
    build_model();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    drive_done();
    step();
    bus.dm_we = '0;
    for (int w = 0; w < 200 && !(xfer_idx >= 2 && bus.rd_req); w++) step();
    check("rst_reached_req", bus.rd_req, 1'b1);
    rst = 1'b1;
    step();
    check_reset_outputs("rst_in_req");
    exp_q.delete();
    rst = 1'b0;
    step();
    check("post_rst_idle_busy", bus.busy, 1'b0);

    // Randomized runs.
    for (int r = 0; r < 6; r++) begin
      logic [NW-1:0] mask;
      mask = NW'($urandom);
      for (int i = 0; i < NW; i++) begin
        gold_mem[i] = $urandom;
        dm_mem[i] = mask[i] ? (gold_mem[i] ^ (32'($urandom) | 32'h1)) : gold_mem[i];
      end
      run_check($urandom_range(0, MAXC - 1), 1'($urandom_range(0, 1)) && 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Hard stop so the bench can never hang.
  initial begin
    #400000;
    n_fail++;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $fatal(1, "time limit");
  end

endmodule
